// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared types, sizing helpers and configuration check for stream_fifo.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package stream_fifo_pkg;

   // Registered occupancy flags, all derived from the post-edge pointers.
   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
   } fifo_flags_t;

   // Sticky error flags; set has priority over clear.
   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   // Pointer carries one extra wrap bit above the memory address bits.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Count must represent 0..DEPTH inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   // True when the parameter set is legal for stream_fifo.
   function automatic bit cfg_ok(input int width, input int depth,
                                 input int afull, input int aempty);
      return (width >= 1) && is_pow2(depth) &&
             (afull >= 1) && (afull <= depth) &&
             (aempty >= 0) && (aempty <= depth - 1);
   endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: simple dual-port WIDTH x DEPTH storage, synchronous write.
// Latency: read 1 cycle (registered), or 0 cycles (asynchronous) when STREAM_FIFO_FWFT_EN is defined.
// Backpressure: none; the caller only issues we/re for accepted transfers.
module stream_fifo_ram
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Storage is deliberately not reset; only the pointers define validity.
   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the accepted word at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef STREAM_FIFO_FWFT_EN
   // Head word is presented combinationally; pop timing is owned by the read pointer.
   assign rdata = mem[raddr];

   logic unused_ok;
   assign unused_ok = ^{rst, re};
`else
   // Registered read port: update only on an accepted read, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: pixel-word FIFO with occupancy, threshold flags and sticky errors (STREAM_FIFO_FWFT_EN selects FWFT read).
// Latency: read data 1 cycle after an accepted read; 0 cycles (head always visible) with STREAM_FIFO_FWFT_EN.
// Backpressure: write while full / read while empty is dropped and latched into overflow / underflow.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int DEPTH         = 4,
   parameter int AFULL_THRESH  = DEPTH - 1,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_fifo_w_stb,
   input  logic [WIDTH-1:0]         i_fifo_w_data,
   output logic                     o_fifo_full,
   output logic                     o_fifo_almost_full,
   input  logic                     i_fifo_r_stb,
   output logic [WIDTH-1:0]         o_fifo_r_data,
   output logic                     o_fifo_empty,
   output logic                     o_fifo_almost_empty,
   output logic [$clog2(DEPTH):0]   o_fifo_count,
   input  logic                     i_fifo_err_clr,
   output logic                     o_fifo_overflow,
   output logic                     o_fifo_underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam int AW = PW - 1;

   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THRESH);
   localparam fifo_flags_t   FLAGS_RST = '{full: 1'b0, almost_full: 1'b0,
                                           empty: 1'b1, almost_empty: 1'b1};

   // Reject illegal parameter sets at elaboration.
   if (!cfg_ok(WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_cfg_err
      $error("stream_fifo: illegal config WIDTH=%0d DEPTH=%0d AFULL_THRESH=%0d AEMPTY_THRESH=%0d",
             WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH);
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;
   logic          wr_acc;
   logic          rd_acc;
   fifo_flags_t   flags_q;
   fifo_flags_t   flags_nxt;
   fifo_err_t     err_q;

   // Accept decisions use the registered (pre-edge) flags only, so a same-cycle
   // read never frees space for a write and a same-cycle write never feeds a read.
   always_comb begin
      wr_acc = i_fifo_w_stb && !flags_q.full;
      rd_acc = i_fifo_r_stb && !flags_q.empty;
   end

   // Next pointers, occupancy and flags as they will be after this edge.
   always_comb begin
      wr_ptr_nxt = wr_acc ? (wr_ptr + PTR_ONE) : wr_ptr;
      rd_ptr_nxt = rd_acc ? (rd_ptr + PTR_ONE) : rd_ptr;
      count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

      flags_nxt              = FLAGS_RST;
      flags_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
      flags_nxt.full         = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                               (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      flags_nxt.almost_full  = (count_nxt >= AFULL_C);
      flags_nxt.almost_empty = (count_nxt <= AEMPTY_C);
   end

   // Pointer, count and flag registers; reset discards all stored words at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         count_q <= count_nxt;
         flags_q <= flags_nxt;
      end
   end

   // Sticky error flags: a set event in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         if (i_fifo_w_stb && flags_q.full) begin
            err_q.overflow <= 1'b1;
         end else if (i_fifo_err_clr) begin
            err_q.overflow <= 1'b0;
         end
         if (i_fifo_r_stb && flags_q.empty) begin
            err_q.underflow <= 1'b1;
         end else if (i_fifo_err_clr) begin
            err_q.underflow <= 1'b0;
         end
      end
   end

   stream_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (i_fifo_w_data),
      .re    (rd_acc),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (o_fifo_r_data)
   );

   assign o_fifo_full         = flags_q.full;
   assign o_fifo_almost_full  = flags_q.almost_full;
   assign o_fifo_empty        = flags_q.empty;
   assign o_fifo_almost_empty = flags_q.almost_empty;
   assign o_fifo_count        = count_q;
   assign o_fifo_overflow     = err_q.overflow;
   assign o_fifo_underflow    = err_q.underflow;

   // Structural invariants of the flag set.
   a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
      !(o_fifo_full && o_fifo_empty));
   a_count_range : assert property (@(posedge clk) disable iff (rst)
      o_fifo_count <= CW'(DEPTH));
   a_empty_is_zero : assert property (@(posedge clk) disable iff (rst)
      o_fifo_empty == (o_fifo_count == '0));

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed plan plus randomized traffic against a queue-based model of stream_fifo.
// Latency: model mirrors 1-cycle registered read, or 0-cycle head visibility with STREAM_FIFO_FWFT_EN.
// Backpressure: model drops writes while full and reads while empty and tracks the sticky errors.
module tb_stream_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFULL = DEPTH - 1;
   localparam int AEMPTY = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             w_stb = 1'b0;
   logic [WIDTH-1:0] w_data = '0;
   logic             r_stb = 1'b0;
   logic             err_clr = 1'b0;
   logic             full, almost_full, empty, almost_empty, overflow, underflow;
   logic [WIDTH-1:0] r_data;
   logic [2:0]       count;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model: a queue of stored words plus the sticky flags.
   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;
   logic [WIDTH-1:0] m_rdata = '0;

   always #5 clk = ~clk;

   stream_fifo #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .AFULL_THRESH  (AFULL),
      .AEMPTY_THRESH (AEMPTY)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_fifo_w_stb        (w_stb),
      .i_fifo_w_data       (w_data),
      .o_fifo_full         (full),
      .o_fifo_almost_full  (almost_full),
      .i_fifo_r_stb        (r_stb),
      .o_fifo_r_data       (r_data),
      .o_fifo_empty        (empty),
      .o_fifo_almost_empty (almost_empty),
      .o_fifo_count        (count),
      .i_fifo_err_clr      (err_clr),
      .o_fifo_overflow     (overflow),
      .o_fifo_underflow    (underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each edge from the pre-edge occupancy and the sampled inputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
         m_rdata = '0;
      end else begin
         automatic int  sz   = q.size();
         automatic bit  do_w = w_stb && (sz < DEPTH);
         automatic bit  do_r = r_stb && (sz > 0);
         if (do_r) m_rdata = q.pop_front();
         if (do_w) q.push_back(w_data);
         if (w_stb && sz == DEPTH) m_ovf = 1'b1;
         else if (err_clr)         m_ovf = 1'b0;
         if (r_stb && sz == 0)     m_udf = 1'b1;
         else if (err_clr)         m_udf = 1'b0;
      end
   end

   // Compare every cycle, half a period after the edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("count",        32'(count),        32'(q.size()));
         check("full",         32'(full),         32'(q.size() == DEPTH));
         check("empty",        32'(empty),        32'(q.size() == 0));
         check("almost_full",  32'(almost_full),  32'(q.size() >= AFULL));
         check("almost_empty", 32'(almost_empty), 32'(q.size() <= AEMPTY));
         check("overflow",     32'(overflow),     32'(m_ovf));
         check("underflow",    32'(underflow),    32'(m_udf));
`ifdef STREAM_FIFO_FWFT_EN
         if (q.size() > 0) check("rdata_head", 32'(r_data), 32'(q[0]));
`else
         check("rdata", 32'(r_data), 32'(m_rdata));
`endif
      end
   end

   // One cycle of stimulus: drive, wait for the edge, settle, return to idle.
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
      w_stb = w; w_data = d; r_stb = r; err_clr = c;
      @(posedge clk);
      #1;
      w_stb = 1'b0; r_stb = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_aempty", 32'(almost_empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_afull", 32'(almost_full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_udf", 32'(underflow), 0);
`ifndef STREAM_FIFO_FWFT_EN
      check("rst_rdata", 32'(r_data), 0);
`endif
      chk_en = 1'b1;

      // Fill with 1..4.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, WIDTH'(i), 1'b0, 1'b0);
         check("fill_count", 32'(count), i);
         check("fill_empty", 32'(empty), 0);
         check("fill_afull", 32'(almost_full), (i >= 3) ? 1 : 0);
         check("fill_full", 32'(full), (i == 4) ? 1 : 0);
      end

      // Overflow, sticky, set wins over clear.
      step(1'b1, 8'h77, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_count", 32'(count), 4);
      step(1'b0, '0, 1'b0, 1'b0);
      check("ovf_sticky", 32'(overflow), 1);
      step(1'b1, 8'h78, 1'b0, 1'b1);
      check("ovf_set_wins", 32'(overflow), 1);

      // Drain in order.
      for (int i = 1; i <= 4; i++) begin
`ifdef STREAM_FIFO_FWFT_EN
         check("drain_head", 32'(r_data), i);
         step(1'b0, '0, 1'b1, 1'b0);
`else
         step(1'b0, '0, 1'b1, 1'b0);
         check("drain_data", 32'(r_data), i);
`endif
      end
      check("drain_empty", 32'(empty), 1);
      step(1'b0, '0, 1'b0, 1'b1);
      check("ovf_clr", 32'(overflow), 0);

      // Underflow on empty read.
      step(1'b0, '0, 1'b1, 1'b0);
      check("udf_set", 32'(underflow), 1);
      check("udf_count", 32'(count), 0);
      step(1'b0, '0, 1'b0, 1'b1);
      check("udf_clr", 32'(underflow), 0);

      // Steady state at count 2 with simultaneous read+write; pointers wrap.
      step(1'b1, 8'h10, 1'b0, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
`ifdef STREAM_FIFO_FWFT_EN
         check("rw_head", 32'(r_data), 32'(8'h10 + i));
         step(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
`else
         step(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
         check("rw_data", 32'(r_data), 32'(8'h10 + i));
`endif
         check("rw_count", 32'(count), 2);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // Full with simultaneous read+write: read taken, write dropped.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      step(1'b1, 8'hB0, 1'b1, 1'b0);
      check("fullrw_count", 32'(count), 3);
      check("fullrw_ovf", 32'(overflow), 1);
`ifdef STREAM_FIFO_FWFT_EN
      check("fullrw_head", 32'(r_data), 32'h0A1);
`else
      check("fullrw_data", 32'(r_data), 32'h0A0);
`endif

      // Asynchronous reset mid-burst at count 3, observed before any edge.
      w_stb = 1'b1; w_data = 8'hC0;
      #2 rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_empty", 32'(empty), 1);
      check("arst_afull", 32'(almost_full), 0);
      check("arst_ovf", 32'(overflow), 0);
`ifndef STREAM_FIFO_FWFT_EN
      check("arst_rdata", 32'(r_data), 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0; w_stb = 1'b0;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef STREAM_FIFO_FWFT_EN
      check("post_rst_head", 32'(r_data), 32'h05A);
      step(1'b0, '0, 1'b1, 1'b0);
`else
      step(1'b0, '0, 1'b1, 1'b0);
      check("post_rst_data", 32'(r_data), 32'h05A);
`endif
      check("post_rst_count", 32'(count), 0);

      // Randomized traffic with varying write/read bias against the model.
      for (int n = 0; n < 3000; n++) begin
         automatic int wp = (n / 200) % 3 == 0 ? 80 : ((n / 200) % 3 == 1 ? 20 : 50);
         automatic int rp = 100 - wp;
         if (n == 1500) begin
            w_stb = 1'b1;
            #2 rst = 1'b1;
            #1 check("rand_arst_count", 32'(count), 0);
            @(posedge clk);
            #1 rst = 1'b0; w_stb = 1'b0;
         end
         step($urandom_range(0, 99) < wp, WIDTH'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 31) == 0);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
